// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared constants and entry type for the IF/ID queue
package if_id_pkg;

  // Instruction presented to decode when the queue has nothing valid
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Byte distance between sequential instructions
  localparam int DEFAULT_PC_STEP = 4;

  // One queued fetch result
  typedef struct packed {
    logic [31:0] pc_add_4;
    logic [31:0] instr;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_q_mem.sv
// rtl/if_id_q_mem.sv - unreset register array, one sync write port, one async read port
module if_id_q_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] storage [DEPTH];

  // Write the pushed entry; contents are never cleared since readers mask by valid
  always_ff @(posedge clk) begin
    if (wr_en) begin
      storage[wr_addr] <= wr_data;
    end
  end

  assign rd_data = storage[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF/ID decoupling queue with flush rewind PC; optional IF_ID_QUEUE_BYPASS_EN empty-queue bypass
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int PC_STEP = DEFAULT_PC_STEP
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc_add_4,
  input  logic [INSTR_W-1:0]         in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc_add_4,
  output logic [INSTR_W-1:0]         out_instr,
  input  logic                       flush,
  output logic [PC_W-1:0]            flush_pc,
  output logic                       flush_pc_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = PC_W + INSTR_W;
  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
  localparam logic [PC_W-1:0] STEP       = PC_W'(PC_STEP);

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [EW-1:0]      rd_data;
  logic [PC_W-1:0]    head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic               not_empty;
  logic               push;
  logic               pop;

  assign not_empty  = (count != '0);
  assign in_ready   = (count != FULL_COUNT);
  assign head_pc    = rd_data[EW-1:INSTR_W];
  assign head_instr = rd_data[INSTR_W-1:0];

`ifdef IF_ID_QUEUE_BYPASS_EN
  logic bypass_active;

  // An empty queue forwards the fetch entry straight to decode
  assign bypass_active = ~not_empty & in_valid & ~flush;
  assign out_valid     = not_empty | bypass_active;
  // A forwarded entry that decode takes this cycle is never stored
  assign push          = in_valid & in_ready & ~flush & ~(bypass_active & out_ready);
  assign pop           = not_empty & out_ready & ~flush;

  // Head outputs: bypassed fetch entry, stored head, or a NOP bubble
  always_comb begin
    out_pc_add_4 = '0;
    out_instr    = INSTR_W'(NOP_INSTR);
    if (bypass_active) begin
      out_pc_add_4 = in_pc_add_4;
      out_instr    = in_instr;
    end else if (not_empty) begin
      out_pc_add_4 = head_pc;
      out_instr    = head_instr;
    end
  end
`else
  assign out_valid = not_empty;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Head outputs: stored head, or a NOP bubble when empty
  always_comb begin
    out_pc_add_4 = '0;
    out_instr    = INSTR_W'(NOP_INSTR);
    if (not_empty) begin
      out_pc_add_4 = head_pc;
      out_instr    = head_instr;
    end
  end
`endif

  if_id_q_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data ({in_pc_add_4, in_instr}),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Occupancy and pointers; flush and reset both empty the queue
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Rewind PC of the oldest killed instruction: the queue head, else the same-cycle fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_pc       <= '0;
      flush_pc_valid <= 1'b0;
    end else begin
      flush_pc_valid <= flush & (not_empty | in_valid);
      if (flush && not_empty) begin
        flush_pc <= head_pc - STEP;
      end else if (flush && in_valid) begin
        flush_pc <= in_pc_add_4 - STEP;
      end
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - self-checking bench for if_id_queue against a queue model
`timescale 1ns/1ps
module tb_if_id_queue;
  import if_id_pkg::*;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
  localparam int PC_STEP = DEFAULT_PC_STEP;
  localparam int CW      = $clog2(DEPTH+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc_add_4;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc_add_4;
  logic [INSTR_W-1:0] out_instr;
  logic               flush;
  logic [PC_W-1:0]    flush_pc;
  logic               flush_pc_valid;
  logic [CW-1:0]      count;

  if_id_queue #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .PC_STEP (PC_STEP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc_add_4    (in_pc_add_4),
    .in_instr       (in_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc_add_4   (out_pc_add_4),
    .out_instr      (out_instr),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .flush_pc_valid (flush_pc_valid),
    .count          (count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue of entries plus the last rewind PC
  if_id_entry_t m_q[$];
  logic [31:0]  m_fpc;
  bit           m_fpv;
  bit           m_push;
  bit           m_pop;
  if_id_entry_t m_ent;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_fpc = '0;
      m_fpv = 1'b0;
    end else if (flush) begin
      if (m_q.size() != 0) begin
        m_fpv = 1'b1;
        m_fpc = m_q[0].pc_add_4 - 32'(PC_STEP);
      end else if (in_valid) begin
        m_fpv = 1'b1;
        m_fpc = in_pc_add_4 - 32'(PC_STEP);
      end else begin
        m_fpv = 1'b0;
      end
      m_q.delete();
    end else begin
      m_fpv  = 1'b0;
      m_push = in_valid && (m_q.size() < DEPTH);
      m_pop  = (m_q.size() != 0) && out_ready;
`ifdef IF_ID_QUEUE_BYPASS_EN
      if (m_q.size() == 0 && in_valid && out_ready) m_push = 1'b0;
`endif
      m_ent.pc_add_4 = in_pc_add_4;
      m_ent.instr    = in_instr;
      if (m_pop)  void'(m_q.pop_front());
      if (m_push) m_q.push_back(m_ent);
    end
  end

  logic        e_valid;
  logic [31:0] e_pc;
  logic [31:0] e_instr;

  // Every mid-cycle, every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      e_valid = (m_q.size() != 0);
      e_pc    = e_valid ? m_q[0].pc_add_4 : 32'h0;
      e_instr = e_valid ? m_q[0].instr : 32'h0;
`ifdef IF_ID_QUEUE_BYPASS_EN
      if (m_q.size() == 0 && in_valid && !flush) begin
        e_valid = 1'b1;
        e_pc    = in_pc_add_4;
        e_instr = in_instr;
      end
`endif
      check("m_out_valid", out_valid, e_valid);
      check("m_out_pc", out_pc_add_4, e_pc);
      check("m_out_instr", out_instr, e_instr);
      check("m_count", count, m_q.size());
      check("m_in_ready", in_ready, m_q.size() != DEPTH);
      check("m_flush_pc_valid", flush_pc_valid, m_fpv);
      check("m_flush_pc", flush_pc, m_fpc);
    end
  end

  task automatic step(input bit rst, input bit iv, input logic [31:0] pc,
                      input logic [31:0] ins, input bit ordy, input bit fl);
    reset       = rst;
    in_valid    = iv;
    in_pc_add_4 = pc;
    in_instr    = ins;
    out_ready   = ordy;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk_en = 1'b1;
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_pc", out_pc_add_4, 0);
    check("rst_fpv", flush_pc_valid, 0);
    check("rst_flush_pc", flush_pc, 0);

    step(1'b0, 1'b1, 32'h04, 32'hA1, 1'b0, 1'b0);
    check("lat1_out_instr", out_instr, 32'hA1);
    step(1'b0, 1'b1, 32'h08, 32'hA2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h0C, 32'hA3, 1'b0, 1'b0);
    check("push3_count", count, 3);
    check("push3_out_instr", out_instr, 32'hA1);
    check("push3_out_valid", out_valid, 1);
    check("push3_out_pc", out_pc_add_4, 32'h04);

    step(1'b0, 1'b1, 32'h10, 32'hA4, 1'b0, 1'b0);
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    step(1'b0, 1'b1, 32'h14, 32'hA5, 1'b0, 1'b0);
    check("no5th_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      check("pop_instr", out_instr, 32'hA1 + i);
      check("pop_pc", out_pc_add_4, 32'h04 + 4 * i);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    check("drained_valid", out_valid, 0);
    check("drained_instr", out_instr, 0);
    check("drained_count", count, 0);

    step(1'b0, 1'b1, 32'h20, 32'hB0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h24, 32'hB1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 32'h28 + 4 * i, 32'hB2 + i, 1'b1, 1'b0);
      check("stream_count", count, 2);
      check("stream_head", out_instr, 32'hB1 + i);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("stream_drain_count", count, 0);

    step(1'b0, 1'b1, 32'h108, 32'hC0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h10C, 32'hC1, 1'b0, 1'b0);
    check("pre_flush_pc", out_pc_add_4, 32'h108);
    step(1'b0, 1'b1, 32'h200, 32'hC2, 1'b0, 1'b1);
    check("flush_count", count, 0);
    check("flush_pc_head", flush_pc, 32'h104);
    check("flush_fpv", flush_pc_valid, 1);
    check("flush_out_valid", out_valid, 0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("flush_pulse_end", flush_pc_valid, 0);
    check("flush_pc_hold", flush_pc, 32'h104);
    check("flush_no_push", count, 0);

    step(1'b0, 1'b1, 32'h0, 32'hD0, 1'b0, 1'b1);
    check("flush_wrap_pc", flush_pc, 32'hFFFF_FFFC);
    check("flush_wrap_fpv", flush_pc_valid, 1);
    check("flush_wrap_count", count, 0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("flush_idle_fpv", flush_pc_valid, 0);
    check("flush_idle_pc", flush_pc, 32'hFFFF_FFFC);

    step(1'b0, 1'b1, 32'h300, 32'hE0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h304, 32'hE1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h308, 32'hE2, 1'b0, 1'b0);
    check("pre_rst_count", count, 3);
    step(1'b1, 1'b1, 32'h400, 32'hE3, 1'b0, 1'b1);
    check("rstfl_count", count, 0);
    check("rstfl_fpv", flush_pc_valid, 0);
    check("rstfl_in_ready", in_ready, 1);
    check("rstfl_flush_pc", flush_pc, 0);
    check("rstfl_out_valid", out_valid, 0);

`ifdef IF_ID_QUEUE_BYPASS_EN
    reset       = 1'b0;
    in_valid    = 1'b1;
    in_pc_add_4 = 32'h500;
    in_instr    = 32'hF0;
    out_ready   = 1'b1;
    flush       = 1'b0;
    #1;
    check("byp_out_valid", out_valid, 1);
    check("byp_out_instr", out_instr, 32'hF0);
    check("byp_out_pc", out_pc_add_4, 32'h500);
    @(posedge clk);
    #1;
    check("byp_count", count, 0);
    step(1'b0, 1'b1, 32'h504, 32'hF1, 1'b0, 1'b0);
    check("byp_stall_count", count, 1);
    check("byp_stall_instr", out_instr, 32'hF1);
`else
    step(1'b0, 1'b1, 32'h500, 32'hF0, 1'b1, 1'b0);
    check("nobyp_count", count, 1);
    check("nobyp_out_instr", out_instr, 32'hF0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("nobyp_pop_count", count, 0);
`endif
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF/ID decoupling stage: a DEPTH-entry in-order queue of {PC+4, instruction} pairs between fetch and decode, with a valid/ready handshake on both sides. It replaces the single-entry IF/ID register. Stall becomes back-pressure, flush empties the whole queue, and a rewind PC for the oldest killed instruction is reported. When the queue is empty, the decode side sees a NOP bubble.

## Interface
Parameters:
- `PC_W`, 32, width of PC+4 field
- `INSTR_W`, 32, instruction width
- `DEPTH`, 4, queue entries; power of two, ≥2
- `PC_STEP`, 4, byte distance between sequential instructions

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high; sampled on `clk` rising edge
- `in_valid`  in  1  fetch presents an entry
- `in_ready`  out  1  queue can accept an entry
- `in_pc_add_4`  in  PC_W  PC+4 of fetched instruction
- `in_instr`  in  INSTR_W  fetched instruction
- `out_valid`  out  1  decode-side entry valid
- `out_ready`  in  1  decode consumes the entry
- `out_pc_add_4`  out  PC_W  PC+4 of head entry
- `out_instr`  out  INSTR_W  head instruction; NOP (all zeros) when `out_valid`=0
- `flush`  in  1  kill all queued entries and any same-cycle push
- `flush_pc`  out  PC_W  PC of oldest killed instruction, i.e. its PC+4 − PC_STEP
- `flush_pc_valid`  out  1  one-cycle pulse; `flush_pc` is meaningful
- `count`  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Push = `in_valid & in_ready & ~flush`.
- Pop = `out_valid & out_ready & ~flush`.
- `in_ready` = (`count` != DEPTH). It has no combinational path from `out_ready`, so a full queue accepts no push even while popping.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are decided by `count`, never by pointer equality.
- Head outputs:
  - `out_valid` = (`count` != 0).
  - `out_pc_add_4` is 0 when `out_valid`=0.
  - `out_instr` is 0 when `out_valid`=0.
- Flush (priority over push and pop):
  - Next cycle `count`=0 and both pointers are 0.
  - `flush_pc_valid`=1 and `flush_pc` = head PC+4 − PC_STEP when `count`≠0.
  - Otherwise, if `in_valid`=1: `flush_pc_valid`=1 and `flush_pc` = `in_pc_add_4` − PC_STEP.
  - Otherwise `flush_pc_valid`=0.
  - The subtraction is modulo 2^PC_W (wraps, no saturation).
- `flush_pc_valid` is high for exactly one cycle per flush cycle. `flush_pc` holds its last value afterward.
- Reset (priority over everything), next cycle:
  - `count`=0, pointers 0.
  - `out_valid`=0, `out_pc_add_4`=0, `out_instr`=0.
  - `in_ready`=1.
  - `flush_pc`=0, `flush_pc_valid`=0.
- A reset mid-stream discards all entries. Storage contents need not be cleared, because outputs are masked by `out_valid`.

## Timing
- Push-to-output latency is 1 cycle (default build): an entry pushed at edge N is visible at `out_*` after edge N.
- `flush_pc`/`flush_pc_valid` are registered and appear after the edge that samples `flush`.
- `count` is registered.
- `in_ready` and `out_valid` are derived from registered `count` only.
- Throughput is one push and one pop per cycle while 0 < `count` < DEPTH.

## Configuration
- Macro `IF_ID_QUEUE_BYPASS_EN`.
- Defined:
  - When `count`=0, `in_valid`=1 and `flush`=0, `out_valid`=1 combinationally, with `out_*` driven directly from `in_*`.
  - If `out_ready`=1 in that cycle, the entry is consumed and not written (`count` stays 0). Otherwise it is written as a normal push.
  - Latency becomes 0 when empty.
- Undefined: strict 1-cycle latency, with no combinational path from `in_*` to `out_*`.

## Structure
- Package `if_id_pkg` holds:
  - `NOP_INSTR` (32'h0000_0000)
  - default `PC_STEP`
  - typedef `if_id_entry_t` {pc_add_4, instr}
- One sub-module, `if_id_q_mem`: DEPTH × (PC_W+INSTR_W) register array with one synchronous write port and one asynchronous read port. No reset on storage.
- Pointers, count, flush-PC logic and output masking live in `if_id_queue`.

## Test plan
- Reset, then push 3 entries (PC+4 = 0x04, 0x08, 0x0C, instr 0xA1, 0xA2, 0xA3) with `out_ready`=0 → `count`=3, `out_instr`=0xA1, `out_valid`=1.
- Fill to DEPTH=4, hold `in_valid`=1 → `in_ready`=0 and no 5th write. Then pop all 4 → values in FIFO order, then `out_instr`=0 and `out_valid`=0.
- Run 10 cycles of continuous push and pop at `count`=2 → `count` stays 2, outputs in order across pointer wrap.
- Flush with head PC+4=0x108 → next cycle `count`=0, `flush_pc`=0x104, `flush_pc_valid`=1 for one cycle. The same-cycle push is not stored.
- Flush while empty, with `in_valid`=1 and `in_pc_add_4`=0x0000_0000 → `flush_pc`=0xFFFF_FFFC. Flush while empty with `in_valid`=0 → `flush_pc_valid`=0.
- Assert `reset` together with `flush` and push at `count`=3 → `count`=0, `flush_pc_valid`=0, `in_ready`=1. With `IF_ID_QUEUE_BYPASS_EN`, push into empty queue with `out_ready`=1 → same-cycle `out_instr`=`in_instr`, `count` stays 0.
